alu_seq: RTL and testbench

- Parametrised, registered successor to the 32-bit combinational ALU.
- Keeps the existing 4-bit opcode map and adds a multi-cycle unsigned multiply plus status flags.
- Uses valid/ready handshakes on both input and output, so it sits between the decode and writeback stages of the CPU datapath.
- Single-cycle ops complete in 1 clock. MUL iterates for WIDTH clocks.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_comb.sv | 72 +++++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared definitions for the registered ALU: opcode map, FSM      |
// |            state encoding, status-flag bit positions and a flag packer.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

  // Opcode map (4-bit). Codes not listed here are illegal.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_XNOR = 4'hB;
  localparam logic [3:0] OP_SLL  = 4'hC;
  localparam logic [3:0] OP_SRL  = 4'hD;
  localparam logic [3:0] OP_SRA  = 4'hE;

  // Sequencer states, explicitly encoded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Bit positions of the status flags inside the packed flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

  function automatic logic [FLAG_W-1:0] pack_flags(
    input logic z,
    input logic n,
    input logic c,
    input logic v
  );
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_comb                                                        |
// | Purpose  : Purely combinational single-cycle datapath covering every       |
// |            opcode except MUL (which is handled iteratively by alu_seq).    |
// | Ports    : a, b     in  WIDTH  operands (b low bits = shift amount)        |
// |            op       in  4      opcode                                      |
// |            result   out WIDTH  operation result (0 for illegal/MUL)        |
// |            carry    out 1      ADD carry out / SUB no-borrow               |
// |            overflow out 1      signed overflow for ADD/SUB                 |
// |            err      out 1      opcode is unassigned                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_shamt;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_shamt = b[SHW-1:0];
  assign w_sum   = {1'b0, a} + {1'b0, b};
  // a + ~b + 1: the extra top bit is the "no borrow" indication (a >= b).
  assign w_diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    err      = 1'b0;
    case (op)
      OP_ADD: begin
        result   = w_sum[WIDTH-1:0];
        carry    = w_sum[WIDTH];
        // Same-signed operands producing an opposite-signed sum.
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = w_diff[WIDTH-1:0];
        carry    = w_diff[WIDTH];
        // Opposite-signed operands where the difference takes b's sign.
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        // Produced by the iterative multiplier in alu_seq.
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_SLL:  result = a << w_shamt;
      OP_SRL:  result = a >> w_shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> w_shamt);
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq                                                         |
// | Purpose  : Registered ALU with valid/ready handshakes on both sides.       |
// |            Single-cycle ops finish in one clock; MUL runs a shift-add      |
// |            loop for WIDTH clocks. Result and flags are held until taken.   |
// | Ports    : clk, rst_n          clock / async active-low reset             |
// |            in_valid, in_ready  input handshake                            |
// |            a, b, op            operands and opcode                        |
// |            out_valid,out_ready output handshake                           |
// |            c                   result                                     |
// |            flag_z/n/c/v        zero, negative, carry, overflow            |
// |            op_err              opcode was unassigned                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             op_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] C_LAST_ITER = SHW'(WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_c;
  logic [FLAG_W-1:0]  r_flags;
  logic               r_op_err;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_count;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_acc_next;

  logic [WIDTH-1:0]   w_comb_res;
  logic               w_comb_carry;
  logic               w_comb_ovf;
  logic               w_comb_err;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (w_comb_res),
    .carry    (w_comb_carry),
    .overflow (w_comb_ovf),
    .err      (w_comb_err)
  );

  assign w_is_mul   = (op == OP_MUL);
  assign w_accept   = in_valid && in_ready;
  assign w_mul_last = (r_state == ST_MUL) && (r_count == C_LAST_ITER);
  // Add the shifted multiplicand when the current multiplier LSB is set.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_is_mul ? ST_MUL : ST_HOLD;
        end
      end
      ST_MUL: begin
        if (w_mul_last) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        // A new op may enter in the same cycle the held result is consumed.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_state_next = w_is_mul ? ST_MUL : ST_HOLD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers and iterative multiplier
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c      <= '0;
      r_flags  <= '0;
      r_op_err <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_count  <= '0;
      end else begin
        r_c      <= w_comb_res;
        r_flags  <= pack_flags(w_comb_res == '0, w_comb_res[WIDTH-1],
                               w_comb_carry, w_comb_ovf);
        r_op_err <= w_comb_err;
      end
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + SHW'(1);
      if (w_mul_last) begin
        r_c      <= w_acc_next[WIDTH-1:0];
        r_flags  <= pack_flags(w_acc_next[WIDTH-1:0] == '0, w_acc_next[WIDTH-1],
                               |w_acc_next[2*WIDTH-1:WIDTH], 1'b0);
        r_op_err <= 1'b0;
      end
    end
  end

  assign c      = r_c;
  assign flag_z = r_flags[FLAG_Z];
  assign flag_n = r_flags[FLAG_N];
  assign flag_c = r_flags[FLAG_C];
  assign flag_v = r_flags[FLAG_V];
  assign op_err = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                      |
// | Purpose  : Self-checking bench for alu_seq (WIDTH=32 and WIDTH=8 copies).  |
// |            Expected results are queued when an op is driven and compared  |
// |            when the result leaves through the output handshake.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  f;    // {z, n, c, v}
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid32 = 1'b0, out_ready32 = 1'b1;
  logic        in_ready32, out_valid32;
  logic [31:0] a32 = '0, b32 = '0, c32;
  logic [3:0]  op32 = '0;
  logic        fz32, fn32, fc32, fv32, err32;

  // 8-bit instance
  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready8, out_valid8;
  logic [7:0]  a8 = '0, b8 = '0, c8;
  logic [3:0]  op8 = '0;
  logic        fz8, fn8, fc8, fv8, err8;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .op(op32), .out_valid(out_valid32), .out_ready(out_ready32),
    .c(c32), .flag_z(fz32), .flag_n(fn32), .flag_c(fc32), .flag_v(fv32), .op_err(err32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .c(c8), .flag_z(fz8), .flag_n(fn8), .flag_c(fc8), .flag_v(fv8), .op_err(err8)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb32[$];
  exp_t sb8[$];
  logic s_ov32, s_ir32, s_ov8, s_ir8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint unsigned x, input int w);
    if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // Behavioural reference built on 64-bit integer arithmetic.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op);
    longint unsigned mask, ua, ub, r;
    longint sa, sb, s, smax, smin;
    int amt;
    logic cf, vf, er;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    ua   = 64'(a) & mask;
    ub   = 64'(b) & mask;
    amt  = int'(ub % 64'(w));
    sa   = sx(ua, w);
    sb   = sx(ub, w);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    r = 0; s = 0; cf = 1'b0; vf = 1'b0; er = 1'b0;
    case (op)
      4'h0: begin r = ua + ub; cf = ((r >> w) & 64'd1) != 0; s = sa + sb; vf = (s > smax) || (s < smin); end
      4'h1: begin r = ua - ub; cf = (ua >= ub);             s = sa - sb; vf = (s > smax) || (s < smin); end
      4'h2: begin r = ua * ub; cf = (r >> w) != 0; end
      4'h8: r = ua & ub;
      4'h9: r = ua | ub;
      4'hA: r = ua ^ ub;
      4'hB: r = ~(ua ^ ub);
      4'hC: r = ua << amt;
      4'hD: r = ua >> amt;
      4'hE: r = $unsigned(sa >>> amt);
      default: er = 1'b1;
    endcase
    r     = r & mask;
    e.c   = 32'(r);
    e.f   = {r == 0, ((r >> (w - 1)) & 64'd1) != 0, cf, vf};
    e.err = er;
    return e;
  endfunction

  // Sample 1ns after the falling edge, retire any result the next rising edge
  // will transfer, then advance to the following falling edge.
  task automatic step();
    exp_t e;
    #1;
    s_ov32 = out_valid32; s_ir32 = in_ready32;
    s_ov8  = out_valid8;  s_ir8  = in_ready8;
    if (out_valid32 && out_ready32) begin
      check("sb32_pending", 64'(sb32.size() != 0), 64'd1);
      if (sb32.size() != 0) begin
        e = sb32.pop_front();
        check("c32", 64'(c32), 64'(e.c));
        check("flags32", 64'({fz32, fn32, fc32, fv32}), 64'(e.f));
        check("op_err32", 64'(err32), 64'(e.err));
      end
    end
    if (out_valid8 && out_ready8) begin
      check("sb8_pending", 64'(sb8.size() != 0), 64'd1);
      if (sb8.size() != 0) begin
        e = sb8.pop_front();
        check("c8", 64'(c8), 64'(e.c));
        check("flags8", 64'({fz8, fn8, fc8, fv8}), 64'(e.f));
        check("op_err8", 64'(err8), 64'(e.err));
      end
    end
    @(negedge clk);
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    a32 = a; b32 = b; op32 = op; in_valid32 = 1'b1;
    sb32.push_back(model(32, a, b, op));
    step();
    check("accept32", 64'(s_ir32), 64'd1);
    in_valid32 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    a8 = a; b8 = b; op8 = op; in_valid8 = 1'b1;
    sb8.push_back(model(8, 32'(a), 32'(b), op));
    step();
    check("accept8", 64'(s_ir8), 64'd1);
    in_valid8 = 1'b0;
  endtask

  // Clocks from accept until out_valid; 100 means the bound expired.
  task automatic wait_valid32(output int lat, output logic ir_seen);
    lat = 0; ir_seen = 1'b0;
    do begin
      step();
      lat++;
      if (!s_ov32 && s_ir32) ir_seen = 1'b1;
    end while (!s_ov32 && lat < 100);
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!s_ov8 && lat < 100);
  endtask

  initial begin
    int   lat;
    logic ir_seen;
    logic ov_seen;
    exp_t e_and;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_c32", 64'(c32), 64'd0);
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_flags32", 64'({fz32, fn32, fc32, fv32, err32}), 64'd0);
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", 64'(s_ir32), 64'd1);

    // ---- reset while a result is held ----
    out_ready32 = 1'b0;
    send32(32'd1, 32'd2, OP_ADD);
    step();
    check("held_before_reset", 64'(s_ov32), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midhold_rst_out_valid", 64'(out_valid32), 64'd0);
    check("midhold_rst_c", 64'(c32), 64'd0);
    sb32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready32 = 1'b1;
    step();

    // ---- ADD overflow ----
    send32(32'h7FFF_FFFF, 32'd1, OP_ADD);
    wait_valid32(lat, ir_seen);
    check("add_latency", 64'(lat), 64'd1);

    // ---- SUB ----
    send32(32'd5, 32'd5, OP_SUB);
    wait_valid32(lat, ir_seen);
    send32(32'd0, 32'd1, OP_SUB);
    wait_valid32(lat, ir_seen);

    // ---- MUL ----
    send32(32'h0001_0000, 32'h0001_0000, OP_MUL);
    wait_valid32(lat, ir_seen);
    check("mul_latency", 64'(lat), 64'd33);
    check("mul_in_ready_low", 64'(ir_seen), 64'd0);

    send32(32'd123, 32'd456, OP_MUL);
    a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; op32 = OP_ADD;  // ignored while busy
    wait_valid32(lat, ir_seen);
    check("mul2_latency", 64'(lat), 64'd33);

    // ---- reset during MUL iteration 10 ----
    send32(32'd7, 32'd9, OP_MUL);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("midmul_rst_out_valid", 64'(out_valid32), 64'd0);
    check("midmul_rst_c", 64'(c32), 64'd0);
    sb32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    repeat (40) begin
      step();
      if (s_ov32) ov_seen = 1'b1;
    end
    check("midmul_no_result", 64'(ov_seen), 64'd0);
    check("midmul_c_cleared", 64'(c32), 64'd0);

    // ---- backpressure on an AND result ----
    out_ready32 = 1'b0;
    e_and = model(32, 32'hF0F0_A5A5, 32'h0FF0_FF00, OP_AND);
    send32(32'hF0F0_A5A5, 32'h0FF0_FF00, OP_AND);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", 64'(s_ov32), 64'd1);
      check("bp_in_ready", 64'(s_ir32), 64'd0);
      check("bp_c", 64'(c32), 64'(e_and.c));
      check("bp_flags", 64'({fz32, fn32, fc32, fv32}), 64'(e_and.f));
    end

    // ---- stream 4 XORs at one op per clock ----
    out_ready32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send32($urandom, $urandom, OP_XOR);
      check("stream_valid", 64'(s_ov32), 64'd1);
    end
    step();
    check("stream_last_valid", 64'(s_ov32), 64'd1);
    step();
    check("stream_drained", 64'(s_ov32), 64'd0);

    // ---- illegal opcode ----
    send32(32'h1234, 32'h5678, 4'h5);
    wait_valid32(lat, ir_seen);
    check("illegal_latency", 64'(lat), 64'd1);

    // ---- shifts on the 8-bit instance ----
    send8(8'h80, 8'h07, OP_SRA);
    wait_valid8(lat);
    check("sra8_latency", 64'(lat), 64'd1);
    send8(8'h80, 8'h07, OP_SRL);
    wait_valid8(lat);
    send8(8'h01, 8'h0B, OP_SLL);
    wait_valid8(lat);
    send8(8'h5A, 8'h08, OP_SLL);
    wait_valid8(lat);
    send8(8'hC3, 8'h10, OP_SRA);
    wait_valid8(lat);
    step();

    check("sb32_empty", 64'(sb32.size()), 64'd0);
    check("sb8_empty", 64'(sb8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
